// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling derived from the system clock.
// Holds the last correctly framed byte behind a level-type valid flag.
module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_en,
    output logic       rx_valid,
    output logic [7:0] rx_out
);

    localparam int BAUD_DIV = CLK_FREQ / (BAUD_RATE * 16);
    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(BAUD_DIV - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic          rx_meta_q, rx_s_q;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [1:0]    state_q, state_d;
    logic [3:0]    smp_cnt_q, smp_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_out_q, rx_out_d;
    logic          rx_valid_q, rx_valid_d;

    assign tick       = (tick_cnt_q == TICK_MAX);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        smp_cnt_d  = smp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rx_out_d   = rx_out_q;
        rx_valid_d = rx_valid_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (rx_en && !rx_s_q) begin
                        state_d   = START;
                        smp_cnt_d = 4'd0;
                    end
                end
                START: begin
                    if (smp_cnt_q == 4'd7) begin
                        if (rx_s_q) begin
                            state_d = IDLE;
                        end else begin
                            rx_valid_d = 1'b0;
                            smp_cnt_d  = 4'd0;
                            bit_cnt_d  = 3'd0;
                            state_d    = DATA;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end
                DATA: begin
                    if (smp_cnt_q == 4'd15) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        smp_cnt_d = 4'd0;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end
                default: begin
                    // Back to IDLE at mid-stop so an abutting start edge is caught.
                    if (smp_cnt_q == 4'd15) begin
                        if (rx_s_q) begin
                            rx_out_d   = shift_q;
                            rx_valid_d = 1'b1;
                        end
                        smp_cnt_d = 4'd0;
                        state_d   = IDLE;
                    end else begin
                        smp_cnt_d = smp_cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            tick_cnt_q <= '0;
            state_q    <= IDLE;
            smp_cnt_q  <= 4'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_out_q   <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            smp_cnt_q  <= smp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rx_out_q   <= rx_out_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign rx_out   = rx_out_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx using a short bit time (BAUD_DIV=4, 64 clk/bit).
// Frames are driven on the falling edge; outputs are checked there too.
module tb_uart_rx;

    localparam int BIT = 64;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       rx_en;
    logic       rx_valid;
    logic [7:0] rx_out;

    int n_cmp;
    int n_bad;

    uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD_RATE(25_000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_en   (rx_en),
        .rx_valid(rx_valid),
        .rx_out  (rx_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_clks(BIT);
    endtask

    task automatic send_tail(input logic [7:0] d, input logic stop);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        send_tail(d, stop);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        rx    = 1'b1;
        rx_en = 1'b1;
        #200;
        @(negedge clk);
        check("reset_valid", {7'd0, rx_valid}, 8'h00);
        check("reset_out", rx_out, 8'h00);
        reset = 1'b0;
        wait_clks(2 * BIT);
        check("idle_valid", {7'd0, rx_valid}, 8'h00);

        send_frame(8'hA5, 1'b1);
        check("a5_out", rx_out, 8'hA5);
        check("a5_valid", {7'd0, rx_valid}, 8'h01);
        wait_clks(BIT);
        check("a5_level", {7'd0, rx_valid}, 8'h01);

        send_frame(8'h3C, 1'b1);
        check("b2b_3c_out", rx_out, 8'h3C);
        check("b2b_3c_valid", {7'd0, rx_valid}, 8'h01);
        send_bit(1'b0);
        check("b2b_drop", {7'd0, rx_valid}, 8'h00);
        check("b2b_hold", rx_out, 8'h3C);
        send_tail(8'hFF, 1'b1);
        check("b2b_ff_out", rx_out, 8'hFF);
        check("b2b_ff_valid", {7'd0, rx_valid}, 8'h01);
        wait_clks(BIT);

        rx = 1'b0;
        wait_clks(12);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("glitch_valid", {7'd0, rx_valid}, 8'h01);
        check("glitch_out", rx_out, 8'hFF);

        send_frame(8'h55, 1'b0);
        rx = 1'b1;
        wait_clks(2 * BIT);
        check("ferr_valid", {7'd0, rx_valid}, 8'h00);
        check("ferr_out", rx_out, 8'hFF);
        send_frame(8'h81, 1'b1);
        check("81_out", rx_out, 8'h81);
        check("81_valid", {7'd0, rx_valid}, 8'h01);
        wait_clks(BIT);

        rx_en = 1'b0;
        send_frame(8'h12, 1'b1);
        wait_clks(BIT);
        check("dis_out", rx_out, 8'h81);
        check("dis_valid", {7'd0, rx_valid}, 8'h01);
        rx_en = 1'b1;
        send_frame(8'h34, 1'b1);
        check("34_out", rx_out, 8'h34);
        check("34_valid", {7'd0, rx_valid}, 8'h01);
        wait_clks(BIT);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        rx = 1'b0;
        wait_clks(BIT / 2);
        reset = 1'b1;
        #1;
        check("rst_valid", {7'd0, rx_valid}, 8'h00);
        check("rst_out", rx_out, 8'h00);
        @(negedge clk);
        rx = 1'b1;
        wait_clks(2);
        reset = 1'b0;
        wait_clks(2 * BIT);
        send_frame(8'hC3, 1'b1);
        check("c3_out", rx_out, 8'hC3);
        check("c3_valid", {7'd0, rx_valid}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
